// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OpMul   = 2'b00,
      OpMulhu = 2'b01,
      OpDivu  = 2'b10,
      OpRemu  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

   localparam int unsigned ITER = 32;
   localparam int unsigned CntW = 6;
   localparam logic [CntW-1:0] LastCnt = CntW'(ITER - 1);

   function automatic logic is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 datapath: shift-add multiply or restoring divide on a shared 64-bit accumulator.
module muldiv_core #(
   parameter int unsigned XLEN = 32
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              load_i,
   input  logic              step_i,
   input  logic              div_i,
   input  logic [XLEN-1:0]   a_i,
   input  logic [XLEN-1:0]   b_i,
   output logic [2*XLEN-1:0] acc_next_o
);

   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   hi, lo;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     rem_diff;
   logic              rem_ge;

   assign hi = acc_q[2*XLEN-1:XLEN];
   assign lo = acc_q[XLEN-1:0];

   always_comb begin
      // Multiply: hi accumulates partial products, lo shifts out multiplier bits.
      mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
      // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
      rem_sh   = {hi, lo[XLEN-1]};
      rem_diff = rem_sh - {1'b0, b_q};
      rem_ge   = (rem_sh >= {1'b0, b_q});
      if (div_i) begin
         acc_next_o = {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                       lo[XLEN-2:0], rem_ge};
      end else begin
         acc_next_o = {mul_sum, lo[XLEN-1:1]};
      end
   end

   always_comb begin
      acc_d = acc_q;
      b_d   = b_q;
      if (load_i) begin
         acc_d = {{XLEN{1'b0}}, a_i};
         b_d   = b_i;
      end else if (step_i) begin
         acc_d = acc_next_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         acc_q <= '0;
         b_q   <= '0;
      end else begin
         acc_q <= acc_d;
         b_q   <= b_d;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage mul/div controller: FSM, iteration counter, pipeline stall and divide-by-zero bypass.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic            flush,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   op_e               op_q, op_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              done_q, done_d;
   logic              div_zero;
   logic              core_load;
   logic              core_step;
   logic [2*XLEN-1:0] acc_next;

   assign div_zero = is_div(op) && (B == '0);

   muldiv_core #(
      .XLEN(XLEN)
   ) u_core (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (core_load),
      .step_i     (core_step),
      .div_i      (is_div(op_q)),
      .a_i        (A),
      .b_i        (B),
      .acc_next_o (acc_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         op_q     <= OpMul;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      result_d = result_q;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start && !flush) begin
               op_d  = op_e'(op);
               cnt_d = '0;
               if (div_zero) begin
                  state_d  = StDone;
                  done_d   = 1'b1;
                  result_d = (op_e'(op) == OpDivu) ? '1 : A;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               state_d = StDone;
               done_d  = 1'b1;
               unique case (op_q)
                  OpMul, OpDivu:   result_d = acc_next[XLEN-1:0];
                  OpMulhu, OpRemu: result_d = acc_next[2*XLEN-1:XLEN];
                  default:         result_d = result_q;
               endcase
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (flush) begin
         state_d  = StIdle;
         done_d   = 1'b0;
         result_d = result_q;
      end
   end

   always_comb begin
      busy      = (state_q != StIdle);
      // While reset is held the FSM is treated as idle so stall tracks start directly.
      stall     = !flush && ((reset || state_q == StIdle) ? start
                                                           : (state_q == StRun));
      core_load = (state_q == StIdle) && start && !flush && !div_zero;
      core_step = (state_q == StRun);
      done      = done_q;
      result    = result_q;
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random ops against an arithmetic model.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        flush;
   logic        stall;
   logic        done;
   logic [31:0] result;
   logic        busy;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [31:0] last_res = '0;

   muldiv_ctrl #(
      .XLEN(32)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .A      (A),
      .B      (B),
      .flush  (flush),
      .stall  (stall),
      .done   (done),
      .result (result),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] prod;
      prod = {32'd0, a} * {32'd0, b};
      case (o)
         2'b00:   return prod[31:0];
         2'b01:   return prod[63:32];
         2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Called just after a rising edge; the current cycle is cycle 0 of the op.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      int          lat;
      exp   = model(o, a, b);
      lat   = (o[1] && b == 0) ? 1 : 33;
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      for (int c = 0; c <= lat; c++) begin
         @(negedge clk);
         check("stall", 32'(stall), (c < lat) ? 32'd1 : 32'd0);
         check("done", 32'(done), (c == lat) ? 32'd1 : 32'd0);
         check("busy", 32'(busy), (c != 0) ? 32'd1 : 32'd0);
         check("result", result, (c == lat) ? exp : last_res);
         @(posedge clk);
         #1;
         // Operands were captured at the first edge; later changes must be ignored.
         A = $urandom;
         B = $urandom;
         if (c == lat) start = 1'b0;
      end
      last_res = exp;
      @(negedge clk);
      check("no_second_done", 32'(done), 32'd0);
      check("idle_after", 32'(busy), 32'd0);
      check("result_hold", result, last_res);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      reset = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      A     = '0;
      B     = '0;
      flush = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      start = 1'b1;
      #1;
      check("rst_stall_start", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("rst_no_capture", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      run_op(2'b00, 32'h0000_0007, 32'h0000_0006);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(2'b10, 32'd100, 32'd7);
      run_op(2'b11, 32'd100, 32'd7);
      run_op(2'b10, 32'h1234_5678, 32'd0);
      run_op(2'b11, 32'h1234_5678, 32'd0);

      // Flush at cycle 10 of a multiply, then a divide starting at cycle 11.
      start = 1'b1;
      op    = 2'b00;
      A     = 32'd1234;
      B     = 32'd5678;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("fl_stall", 32'(stall), 32'd1);
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      #1;
      check("fl_stall_drop", 32'(stall), 32'd0);
      @(negedge clk);
      check("fl_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      start = 1'b0;
      run_op(2'b10, 32'd9, 32'd3);

      // Flush against a divide-by-zero start: must not produce done.
      start = 1'b1;
      op    = 2'b10;
      A     = 32'd55;
      B     = 32'd0;
      flush = 1'b1;
      @(negedge clk);
      check("fl0_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      check("fl0_done", 32'(done), 32'd0);
      check("fl0_result", result, last_res);
      @(posedge clk);
      #1;

      // Reset at cycle 20 of a divide.
      start = 1'b1;
      op    = 2'b10;
      A     = 32'd1000;
      B     = 32'd3;
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("mr_stall", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      last_res = '0;
      @(negedge clk);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_done", 32'(done), 32'd0);
      check("mr_result", result, 32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 255));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 15));
         run_op(ro, ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
